// File: rtl/ps2_kbd_device_tx.sv
// Device-side PS/2 keyboard transmitter: key event -> [E0][F0] code byte frames on open-collector lines.
// Optional PS2_TX_RETRY_EN: resend an aborted byte instead of dropping the rest of the event.
module ps2_kbd_device_tx #(
  parameter int HALF_CYC = 2500,
  parameter int GAP_CYC  = 5000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] key_code,
  input  logic       key_ext,
  input  logic       key_brk,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done_pulse,
  output logic       abort_pulse
);
  localparam int CMAX = (HALF_CYC > GAP_CYC) ? HALF_CYC : GAP_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHK, S_BIT_HI, S_BIT_LO, S_GAP, S_ABORT
  } state_t;

  state_t        r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [3:0]    r_bit, w_bit_next;
  logic [1:0]    r_idx, w_idx_next;
  logic [1:0]    r_last_idx;
  logic [7:0]    r_byte0, r_byte1, r_byte2;
  logic [10:0]   r_frame;
  logic          r_clk_meta, r_clk_sync, r_dat_meta, r_dat_sync;
  logic          r_done;
  logic          w_accept, w_load_frame, w_done_set;
  logic [7:0]    w_byte;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_idx      <= '0;
      r_done     <= 1'b0;
      r_clk_meta <= 1'b1;
      r_clk_sync <= 1'b1;
      r_dat_meta <= 1'b1;
      r_dat_sync <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_bit      <= w_bit_next;
      r_idx      <= w_idx_next;
      r_done     <= w_done_set;
      r_clk_meta <= ps2_clk_in;
      r_clk_sync <= r_clk_meta;
      r_dat_meta <= ps2_dat_in;
      r_dat_sync <= r_dat_meta;
    end
  end

  // Byte slots hold the prefix bytes followed by the code; unused slots are don't-care.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_byte0    <= key_ext ? 8'hE0 : (key_brk ? 8'hF0 : key_code);
      r_byte1    <= (key_ext && key_brk) ? 8'hF0 : key_code;
      r_byte2    <= key_code;
      r_last_idx <= 2'(key_ext) + 2'(key_brk);
    end
    if (w_load_frame) begin
      r_frame <= {1'b1, ~^w_byte, w_byte, 1'b0};
    end
  end

  always_comb begin
    case (r_idx)
      2'd0:    w_byte = r_byte0;
      2'd1:    w_byte = r_byte1;
      default: w_byte = r_byte2;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_bit_next   = r_bit;
    w_idx_next   = r_idx;
    w_accept     = 1'b0;
    w_load_frame = 1'b0;
    w_done_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (key_valid) begin
          w_accept     = 1'b1;
          w_idx_next   = '0;
          w_cnt_next   = '0;
          w_state_next = S_CHK;
        end
      end
      S_CHK: begin
        if (r_clk_sync && r_dat_sync) begin
          if (r_cnt == HALF_LAST) begin
            w_load_frame = 1'b1;
            w_bit_next   = '0;
            w_cnt_next   = '0;
            w_state_next = S_BIT_HI;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end else begin
          w_cnt_next = '0;
        end
      end
      S_BIT_HI: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_next   = '0;
          // Clock still low after our release means the host is inhibiting.
          w_state_next = r_clk_sync ? S_BIT_LO : S_ABORT;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_BIT_LO: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_next = '0;
          if (r_bit == 4'd10) begin
            w_state_next = S_GAP;
          end else begin
            w_bit_next   = r_bit + 1'b1;
            w_state_next = S_BIT_HI;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_cnt_next = '0;
          if (r_idx == r_last_idx) begin
            w_done_set   = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_idx_next   = r_idx + 1'b1;
            w_state_next = S_CHK;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_ABORT: begin
        w_cnt_next = '0;
`ifdef PS2_TX_RETRY_EN
        w_state_next = S_CHK;
`else
        w_state_next = S_IDLE;
`endif
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign key_ready   = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign ps2_clk_oe  = (r_state == S_BIT_LO);
  assign ps2_dat_oe  = ((r_state == S_BIT_HI) || (r_state == S_BIT_LO)) && !r_frame[r_bit];
  assign done_pulse  = r_done;
  assign abort_pulse = (r_state == S_ABORT);
endmodule

// File: doc/ps2_kbd_device_tx.md
Name: ps2_kbd_device_tx

Overview:
- Device-side PS/2 keyboard transmitter: the keyboard end of the link.
- Turns key events (scan code plus extended/break flags) into the PS/2 byte sequence.
- Serialises each byte as an 11-bit device-to-host frame, generating PS2 clock itself on open-collector lines.
- Used as a keyboard emulator for bench/loopback testing of the host receive path and for board-to-board links.

Parameters:
- HALF_CYC, 2500, clk cycles per PS/2 clock half-period (50 MHz -> 10 kHz bus clock).
- GAP_CYC, 5000, idle cycles between consecutive bytes of one event.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- key_code  in  8  scan code to send.
- key_ext  in  1  event is extended; prefix 0xE0.
- key_brk  in  1  event is a release; prefix 0xF0.
- key_valid  in  1  event offered.
- key_ready  out  1  block can accept an event.
- ps2_clk_in  in  1  sensed PS2_CLK line (async).
- ps2_dat_in  in  1  sensed PS2_DAT line (async).
- ps2_clk_oe  out  1  1 = pull PS2_CLK low, 0 = release.
- ps2_dat_oe  out  1  1 = pull PS2_DAT low, 0 = release.
- busy  out  1  event in progress.
- done_pulse  out  1  1-cycle pulse when the last byte of an event completes.
- abort_pulse  out  1  1-cycle pulse when a frame is aborted by host inhibit.

Behaviour:
- Reset values: ps2_clk_oe=0, ps2_dat_oe=0, busy=0, done_pulse=0, abort_pulse=0, state IDLE, so key_ready=1 the cycle after reset deasserts. Reset mid-frame releases both lines on the next edge.
- Sync: ps2_clk_in and ps2_dat_in pass through 2-FF synchronisers. All line checks use the synchronised values.
- Handshake: key_ready=1 only in IDLE. An event is accepted when key_valid&&key_ready. key_code, key_ext and key_brk are captured that cycle. key_valid while busy is ignored.
- Byte sequence per event:
  - make: [code]
  - ext make: [E0, code]
  - break: [F0, code]
  - ext break: [E0, F0, code]
  - Byte index counter 0..2; sequence length 1..3.
- Frame: start 0, d0..d7 LSB first, odd parity (ones in data+parity odd), stop 1. 11 bits total.
- States:
  - IDLE: waits for an accepted event; goes to CHK.
  - CHK: waits until both lines are high for HALF_CYC consecutive cycles; any low resets the counter. Then loads the byte and goes to BIT_HI with bit=0.
  - BIT_HI: ps2_clk_oe=0, ps2_dat_oe=~frame[bit], held HALF_CYC cycles. On the last cycle, if synchronised clk is low (host inhibit), go to ABORT; else go to BIT_LO.
  - BIT_LO: ps2_clk_oe=1 for HALF_CYC cycles; data unchanged. Then bit<10 -> BIT_HI with bit+1; bit==10 -> GAP.
  - GAP: both lines released for GAP_CYC cycles. More bytes -> CHK with next byte. Otherwise done_pulse=1 and go to IDLE.
  - ABORT: both lines released, abort_pulse=1 for one cycle, then action per the optional feature.
- Timing: data changes only while the clock is released (high). The host samples on the falling clock edge. The line is pulled low exactly 11 times per successful frame.
- busy=1 in every state except IDLE.
- Line held low at start (host inhibit or host request-to-send): the block stays in CHK indefinitely; no clock edges are generated.

Optional Feature:
- PS2_TX_RETRY_EN defined: after ABORT, return to CHK and resend the same byte. Remaining bytes of the event are kept. done_pulse fires only after the final byte completes.
- PS2_TX_RETRY_EN undefined: after ABORT, drop the rest of the event and go to IDLE. No done_pulse for that event.

Test Plan (HALF_CYC=8, GAP_CYC=16; bench models a host with pull-ups sampling data on falling clk):
- Make 0x1C, no flags -> one frame; host samples bits 0,0,0,1,1,1,0,0,0,0,1 (parity 0). Exactly 11 falling edges, done_pulse once, busy falls with it.
- Ext break 0x75 -> three frames: E0 (parity 0), F0 (parity 1), 75 (parity 0), separated by at least 16 idle cycles. Single done_pulse after the third stop bit.
- Host holds clk low during bit 4 of byte F0 -> abort_pulse. With RETRY_EN: F0 resent in full after release, then 75, then done_pulse. Without RETRY_EN: return to IDLE, no done_pulse, key_ready=1.
- Host holds data low before the event -> no clock activity while held. Transmission starts 8+ cycles after release.
- reset asserted mid-frame (bit 6) -> next cycle both oe=0, busy=0, done_pulse=0. key_ready=1 after reset.
- key_valid pulsed with new code while busy -> ignored. Only the first event appears on the bus.
